dcache_req_ctrl: RTL and testbench

Sequencer between the memory pipeline stage and the data cache. It accepts one load/store per request from the exe1 stage and drives the cache request until the address is accepted. It then waits for completion, aligns load data and sign- or zero-extends it, returns it for writeback, and stalls the pipeline while an access is in flight.

---
 rtl/dcache_req_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_dcache_req_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_req_ctrl
//  Description : Sequencer between the memory pipeline stage and the data
//                cache. Captures one load/store from exe1, drives the cache
//                request until the address is accepted, waits for
//                completion, then aligns and extends load data for writeback.
//                The upstream pipeline is stalled while an access is in
//                flight.
//
//  Ports
//    clk, rstn           clock; synchronous active-low reset
//    req_*               load/store request from exe1
//    flush               cancels the current or incoming access
//    valid, op, addr,    cache request (op: 1 write, 0 read)
//    write_type,
//    w_data_CPU          byte enables and lane-replicated store data
//    addr_valid          cache accepted the request this cycle
//    data_valid          read data returned / write completed
//    r_data_CPU          cache read word
//    wb_valid, wb_rd,    one-cycle load writeback
//    wb_data
//    stall_because_cache hold upstream while state != IDLE
//    exp_ale             one-cycle misaligned-access pulse
//
//  Configuration
//    DCACHE_ALIGN_CHECK_EN  defined  : misaligned half/word requests are
//                                      rejected and flagged on exp_ale.
//                           undefined: exp_ale tied low; misaligned low
//                                      address bits are forced to zero.
//
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_req_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        valid,
    output logic        op,
    output logic [31:0] addr,
    output logic [3:0]  write_type,
    output logic [31:0] w_data_CPU,
    input  logic        addr_valid,
    input  logic        data_valid,
    input  logic [31:0] r_data_CPU,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall_because_cache,
    output logic        exp_ale
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] c_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] c_WIDTH_HALF = 2'b01;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_kill;
    logic        w_kill_nxt;

    logic        r_op;
    logic [31:0] r_addr;
    logic [3:0]  r_write_type;
    logic [31:0] r_wdata_lane;
    logic [1:0]  r_width;
    logic        r_signed;
    logic [4:0]  r_rd;

    logic        r_wb_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_complete;
    logic [31:0] w_cap_addr;
    logic [3:0]  w_cap_write_type;
    logic [31:0] w_cap_wdata;
    logic [31:0] w_rdata_shifted;
    logic [15:0] w_rdata_half;
    logic [31:0] w_load_result;

    // ------------------------------------------------------------------
    // Request acceptance and address capture
    // ------------------------------------------------------------------
`ifdef DCACHE_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_exp_ale;

    assign w_misaligned = ((req_width == c_WIDTH_HALF) & req_addr[0]) |
                          (req_width[1] & (|req_addr[1:0]));
    assign w_accept     = (r_state == S_IDLE) & req_valid & ~flush & ~w_misaligned;
    assign w_cap_addr   = req_addr;
    assign exp_ale      = r_exp_ale;
`else
    assign w_accept = (r_state == S_IDLE) & req_valid & ~flush;

    // Misaligned low bits are dropped so the cache always sees a naturally
    // aligned half/word address.
    always_comb begin
        w_cap_addr = req_addr;
        if (req_width == c_WIDTH_HALF) begin
            w_cap_addr[0] = 1'b0;
        end else if (req_width[1]) begin
            w_cap_addr[1:0] = 2'b00;
        end
    end

    assign exp_ale = 1'b0;
`endif

    always_comb begin
        w_cap_write_type = 4'b1111;
        w_cap_wdata      = req_wdata;
        if (req_width == c_WIDTH_BYTE) begin
            w_cap_write_type = 4'b0001 << w_cap_addr[1:0];
            w_cap_wdata      = {4{req_wdata[7:0]}};
        end else if (req_width == c_WIDTH_HALF) begin
            w_cap_write_type = 4'b0011 << {w_cap_addr[1], 1'b0};
            w_cap_wdata      = {2{req_wdata[15:0]}};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (addr_valid & data_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (addr_valid) begin
                    w_state_nxt = S_WAIT;
                end else if (flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (data_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The kill flag only matters while an accepted address is outstanding;
    // it is cleared whenever the controller returns to IDLE.
    always_comb begin
        w_kill_nxt = 1'b0;
        if (w_state_nxt != S_IDLE) begin
            w_kill_nxt = r_kill | (flush & (r_state != S_IDLE));
        end
    end

    assign w_complete = ((r_state == S_REQ)  & addr_valid & data_valid) |
                        ((r_state == S_WAIT) & data_valid);

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    assign w_rdata_shifted = r_data_CPU >> {r_addr[1:0], 3'b000};
    assign w_rdata_half    = r_addr[1] ? r_data_CPU[31:16] : r_data_CPU[15:0];

    always_comb begin
        w_load_result = r_data_CPU;
        if (r_width == c_WIDTH_BYTE) begin
            w_load_result = {{24{r_signed & w_rdata_shifted[7]}}, w_rdata_shifted[7:0]};
        end else if (r_width == c_WIDTH_HALF) begin
            w_load_result = {{16{r_signed & w_rdata_half[15]}}, w_rdata_half};
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_kill       <= 1'b0;
            r_op         <= 1'b0;
            r_addr       <= 32'd0;
            r_write_type <= 4'd0;
            r_wdata_lane <= 32'd0;
            r_width      <= 2'd0;
            r_signed     <= 1'b0;
            r_rd         <= 5'd0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;

            if (w_accept) begin
                r_op         <= req_write;
                r_addr       <= w_cap_addr;
                r_write_type <= w_cap_write_type;
                r_wdata_lane <= w_cap_wdata;
                r_width      <= req_width;
                r_signed     <= req_signed;
                r_rd         <= req_rd;
            end

            // A flush arriving in the completion cycle also cancels the
            // writeback of the access being completed.
            r_wb_valid <= w_complete & ~r_op & ~r_kill & ~flush;
            if (w_complete) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_load_result;
            end
        end
    end

`ifdef DCACHE_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_exp_ale <= 1'b0;
        end else begin
            r_exp_ale <= (r_state == S_IDLE) & req_valid & ~flush & w_misaligned;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid               = (r_state == S_REQ);
    assign op                  = r_op;
    assign addr                = r_addr;
    assign write_type          = r_write_type;
    assign w_data_CPU          = r_wdata_lane;
    assign wb_valid            = r_wb_valid;
    assign wb_rd               = r_wb_rd;
    assign wb_data             = r_wb_data;
    assign stall_because_cache = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dcache_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_req_ctrl
//  Description : Self-checking bench for dcache_req_ctrl. Directed scenarios
//                followed by randomized transactions compared against a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_req_ctrl;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_width;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        flush;
    logic        valid;
    logic        op;
    logic [31:0] addr;
    logic [3:0]  write_type;
    logic [31:0] w_data_CPU;
    logic        addr_valid;
    logic        data_valid;
    logic [31:0] r_data_CPU;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_because_cache;
    logic        exp_ale;

    int n_checks;
    int n_pass;

    dcache_req_ctrl u_dut (
        .clk                 (clk),
        .rstn                (rstn),
        .req_valid           (req_valid),
        .req_write           (req_write),
        .req_width           (req_width),
        .req_signed          (req_signed),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_rd              (req_rd),
        .flush               (flush),
        .valid               (valid),
        .op                  (op),
        .addr                (addr),
        .write_type          (write_type),
        .w_data_CPU          (w_data_CPU),
        .addr_valid          (addr_valid),
        .data_valid          (data_valid),
        .r_data_CPU          (r_data_CPU),
        .wb_valid            (wb_valid),
        .wb_rd               (wb_rd),
        .wb_data             (wb_data),
        .stall_because_cache (stall_because_cache),
        .exp_ale             (exp_ale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (transaction level, straight from the rules)
    // ------------------------------------------------------------------
    function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] wd);
        if (wd == 2'd1) return (a % 2) != 0;
        if (wd >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [1:0] wd);
`ifdef DCACHE_ALIGN_CHECK_EN
        return a;
`else
        if (wd == 2'd1) return a - (a % 2);
        if (wd >= 2'd2) return a - (a % 4);
        return a;
`endif
    endfunction

    function automatic logic [3:0] m_we(input logic [31:0] a, input logic [1:0] wd);
        int ofs;
        ofs = int'(a % 4);
        if (wd == 2'd0) return 4'(1 << ofs);
        if (wd == 2'd1) return (ofs >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] d, input logic [1:0] wd);
        if (wd == 2'd0) return (d % 256) * 32'h0101_0101;
        if (wd == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] r, input logic [31:0] a,
                                           input logic [1:0] wd, input logic sg);
        logic [31:0] v;
        if (wd == 2'd0) begin
            v = (r >> (8 * int'(a % 4))) % 256;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (wd == 2'd1) begin
            v = (r >> (16 * int'((a % 4) / 2))) % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // One transaction. Entered and left at a negedge with the DUT idle.
    //   d1    : REQ cycles before addr_valid
    //   both  : data_valid together with addr_valid
    //   d2    : WAIT cycles before data_valid
    //   fmode : 0 none, 1 flush in REQ before addr_valid,
    //           2 flush with addr_valid, 3 flush in first WAIT cycle,
    //           4 flush with the request in IDLE
    // ------------------------------------------------------------------
    task automatic run_txn(input logic w, input logic [1:0] wd, input logic sg,
                           input logic [31:0] a, input logic [31:0] wdat,
                           input logic [4:0] rd, input logic [31:0] rdat,
                           input int d1, input logic both, input int d2, input int fmode);
        logic [31:0] ea;
        logic        expect_wb;
        ea = m_addr(a, wd);

        chk("idle_stall", 32'(stall_because_cache), 32'd0);
        req_valid  = 1'b1;
        req_write  = w;
        req_width  = wd;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wdat;
        req_rd     = rd;
        r_data_CPU = rdat;
        flush      = (fmode == 4);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;

        if (fmode == 4) begin
            chk("flush_ign_valid", 32'(valid), 32'd0);
            chk("flush_ign_stall", 32'(stall_because_cache), 32'd0);
            return;
        end
`ifdef DCACHE_ALIGN_CHECK_EN
        if (is_misaligned(a, wd)) begin
            chk("ale_pulse", 32'(exp_ale), 32'd1);
            chk("ale_valid", 32'(valid), 32'd0);
            chk("ale_stall", 32'(stall_because_cache), 32'd0);
            @(negedge clk);
            chk("ale_once", 32'(exp_ale), 32'd0);
            chk("ale_valid2", 32'(valid), 32'd0);
            return;
        end
`endif

        for (int i = 0; i <= d1; i++) begin
            chk("req_valid", 32'(valid), 32'd1);
            chk("req_op", 32'(op), 32'(w));
            chk("req_addr", addr, ea);
            chk("req_we", 32'(write_type), 32'(m_we(ea, wd)));
            chk("req_wdata", w_data_CPU, m_wd(wdat, wd));
            chk("req_stall", 32'(stall_because_cache), 32'd1);
            chk("req_nowb", 32'(wb_valid), 32'd0);
            chk("req_noale", 32'(exp_ale), 32'd0);
            if (fmode == 1 && i == 0) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                chk("rflush_valid", 32'(valid), 32'd0);
                chk("rflush_stall", 32'(stall_because_cache), 32'd0);
                chk("rflush_nowb", 32'(wb_valid), 32'd0);
                return;
            end
            if (i < d1) begin
                @(negedge clk);
            end else begin
                addr_valid = 1'b1;
                data_valid = both;
                flush      = (fmode == 2);
                @(negedge clk);
                addr_valid = 1'b0;
                data_valid = 1'b0;
                flush      = 1'b0;
            end
        end

        if (!both) begin
            for (int j = 0; j <= d2; j++) begin
                chk("wait_valid", 32'(valid), 32'd0);
                chk("wait_stall", 32'(stall_because_cache), 32'd1);
                chk("wait_nowb", 32'(wb_valid), 32'd0);
                if (j < d2) begin
                    flush = (fmode == 3 && j == 0);
                    @(negedge clk);
                    flush = 1'b0;
                end else begin
                    data_valid = 1'b1;
                    @(negedge clk);
                    data_valid = 1'b0;
                end
            end
        end

        expect_wb = !w && (fmode == 0);
        chk("done_stall", 32'(stall_because_cache), 32'd0);
        chk("done_wb_valid", 32'(wb_valid), 32'(expect_wb));
        if (expect_wb) begin
            chk("done_wb_rd", 32'(wb_rd), 32'(rd));
            chk("done_wb_data", wb_data, m_load(rdat, ea, wd, sg));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_op"}, 32'(op), 32'd0);
        chk({tag, "_addr"}, addr, 32'd0);
        chk({tag, "_we"}, 32'(write_type), 32'd0);
        chk({tag, "_wdata"}, w_data_CPU, 32'd0);
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wbdata"}, wb_data, 32'd0);
        chk({tag, "_ale"}, 32'(exp_ale), 32'd0);
        chk({tag, "_stall"}, 32'(stall_because_cache), 32'd0);
    endtask

    initial begin
        int   fm;
        logic bt;
        int   dd2;
        n_checks   = 0;
        n_pass     = 0;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_width  = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        flush      = 1'b0;
        addr_valid = 1'b0;
        data_valid = 1'b0;
        r_data_CPU = 32'd0;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Directed scenarios
        run_txn(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 5'd7, 32'h80FF_0000, 0, 1'b1, 0, 0);
        run_txn(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 5'd3, 32'd0, 0, 1'b1, 0, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_4008, 32'd0, 5'd9, 32'hDEAD_BEEF, 3, 1'b0, 2, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0, 5'd1, 32'h1234_5678, 2, 1'b0, 1, 1);
        run_txn(1'b0, 2'd1, 1'b1, 32'h0000_6002, 32'd0, 5'd2, 32'h8001_0000, 0, 1'b0, 2, 3);
        run_txn(1'b0, 2'd1, 1'b1, 32'h0000_3001, 32'd0, 5'd4, 32'hCAFE_F00D, 1, 1'b1, 0, 0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h0000_7000, 32'd0, 5'd6, 32'h0000_0000, 0, 1'b1, 0, 4);

        // Reset while WAIT: outputs cleared, late data_valid ignored
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_width  = 2'd2;
        req_addr   = 32'h0000_0040;
        req_rd     = 5'd12;
        r_data_CPU = 32'h5555_AAAA;
        @(negedge clk);
        req_valid  = 1'b0;
        addr_valid = 1'b1;
        @(negedge clk);
        addr_valid = 1'b0;
        chk("rstw_stall", 32'(stall_because_cache), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk_all_zero("rstw");
        rstn       = 1'b1;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk("rstw_late_wb", 32'(wb_valid), 32'd0);
        chk("rstw_late_stall", 32'(stall_because_cache), 32'd0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h0000_0041, 32'd0, 5'd13, 32'h0000_9A00, 1, 1'b0, 0, 0);

        // Randomized transactions
        for (int t = 0; t < 300; t++) begin
            fm = int'($urandom_range(0, 9));
            fm = (fm <= 5) ? 0 : fm - 5;
            bt = 1'($urandom_range(0, 1));
            dd2 = int'($urandom_range(0, 3));
            if (fm == 2 || fm == 3) bt = 1'b0;
            if (fm == 3 && dd2 == 0) dd2 = 1;
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom,
                    int'($urandom_range(0, 3)), bt, dd2, fm);
        end

        // Final pulse must last one cycle only
        @(negedge clk);
        chk("final_nowb", 32'(wb_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
